// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - shared types and constants for the branch redirect controller
// Purpose : FSM state type, RV opcode/funct3 constants, default widths.
// Ports   : none (package).
package branch_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int INFLIGHT_W = 3;   // enough for 0..7 wrong-path responses

    localparam logic [6:0] OP_BRANCH = 7'b110_0011;
    localparam logic [6:0] OP_JAL    = 7'b110_1111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_SQUASH   = 2'd2
    } brc_state_t;

    // Targets must be word aligned; anything else traps instead of redirecting.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/redirect_squash_cnt.sv
// rtl/redirect_squash_cnt.sv - loadable down-counter of wrong-path responses still to drop
// Purpose : counts outstanding wrong-path imem responses after a redirect.
// Ports   : clk, rst_n (async active-low), i_load/i_load_val (load),
//           i_dec (decrement), o_cnt (value), o_zero (cnt==0), o_last (cnt==1).
module redirect_squash_cnt
    import branch_pkg::*;
#(
    parameter int W = INFLIGHT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic [W-1:0] o_cnt,
    output logic         o_zero,
    output logic         o_last
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == '0);
    assign o_last = (r_cnt == W'(1));

endmodule

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - sequences fetch redirect, flushes and wrong-path squash for taken branches
// Purpose : turns a taken EX branch/jump into a valid/ready redirect to fetch,
//           flushes IF/ID and ID/EX, drops in-flight wrong-path imem responses,
//           and raises a one-cycle trap for misaligned targets.
// Ports   : clk, rst_n (async active-low); ex_valid, ex_br_en, ex_target (EX);
//           fetch_ready, imem_rsp_valid (fetch side); redirect_valid, redirect_pc,
//           flush_ifid, flush_idex, stall_ex, squash_rsp, misalign_trap,
//           trap_addr, taken_count (outputs).
module branch_redirect_ctrl
    import branch_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int INFLIGHT = 2,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic             ex_br_en,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             fetch_ready,
    input  logic             imem_rsp_valid,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             stall_ex,
    output logic             squash_rsp,
    output logic             misalign_trap,
    output logic [XLEN-1:0]  trap_addr,
    output logic [CNT_W-1:0] taken_count
);

    localparam logic [INFLIGHT_W-1:0] LP_INFLIGHT = INFLIGHT_W'(INFLIGHT);

    brc_state_t             r_state;
    logic                   r_redirect_valid;
    logic [XLEN-1:0]        r_redirect_pc;
    logic                   r_flush_ifid;
    logic                   r_flush_idex;
    logic                   r_stall_ex;
    logic                   r_trap;
    logic [XLEN-1:0]        r_trap_addr;
    logic [CNT_W-1:0]       r_taken_count;

    logic                   w_trigger;
    logic                   w_accept;
    logic                   w_dec;
    logic [INFLIGHT_W-1:0]  w_sq_cnt;
    logic                   w_sq_zero;
    logic                   w_sq_last;

    assign w_trigger = ex_valid && ex_br_en;
    assign w_accept  = (r_state == ST_REDIRECT) && fetch_ready;
    assign w_dec     = (r_state == ST_SQUASH) && imem_rsp_valid;

    redirect_squash_cnt #(
        .W (INFLIGHT_W)
    ) u_squash_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_accept && (INFLIGHT != 0)),
        .i_load_val (LP_INFLIGHT),
        .i_dec      (w_dec),
        .o_cnt      (w_sq_cnt),
        .o_zero     (w_sq_zero),
        .o_last     (w_sq_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_flush_ifid     <= 1'b0;
            r_flush_idex     <= 1'b0;
            r_stall_ex       <= 1'b0;
            r_trap           <= 1'b0;
            r_trap_addr      <= '0;
            r_taken_count    <= '0;
        end else begin
            r_trap <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_trigger) begin
                        if (is_misaligned(ex_target[1:0])) begin
                            r_trap      <= 1'b1;
                            r_trap_addr <= ex_target;
                        end else begin
                            r_redirect_pc    <= ex_target;
                            r_state          <= ST_REDIRECT;
                            r_redirect_valid <= 1'b1;
                            r_flush_ifid     <= 1'b1;
                            r_flush_idex     <= 1'b1;
                            r_stall_ex       <= 1'b1;
                        end
                    end
                end
                ST_REDIRECT: begin
                    if (fetch_ready) begin
                        r_taken_count    <= r_taken_count + CNT_W'(1);
                        r_redirect_valid <= 1'b0;
                        r_flush_idex     <= 1'b0;
                        if (INFLIGHT == 0) begin
                            r_state      <= ST_IDLE;
                            r_flush_ifid <= 1'b0;
                            r_stall_ex   <= 1'b0;
                        end else begin
                            r_state <= ST_SQUASH;
                        end
                    end
                end
                ST_SQUASH: begin
                    // The zero check only guards against a counter that was never
                    // loaded, so SQUASH can never wait forever.
                    if ((w_dec && w_sq_last) || w_sq_zero) begin
                        r_state      <= ST_IDLE;
                        r_flush_ifid <= 1'b0;
                        r_stall_ex   <= 1'b0;
                    end
                end
                default: begin
                    r_state          <= ST_IDLE;
                    r_redirect_valid <= 1'b0;
                    r_flush_ifid     <= 1'b0;
                    r_flush_idex     <= 1'b0;
                    r_stall_ex       <= 1'b0;
                end
            endcase
        end
    end

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign flush_ifid     = r_flush_ifid;
    assign flush_idex     = r_flush_idex;
    assign stall_ex       = r_stall_ex;
    assign squash_rsp     = w_dec;
    assign misalign_trap  = r_trap;
    assign trap_addr      = r_trap_addr;
    assign taken_count    = r_taken_count;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb/tb_branch_redirect_ctrl.sv - checks branch_redirect_ctrl (INFLIGHT=2 and INFLIGHT=0) against a reference model
module tb_branch_redirect_ctrl;

    localparam int XLEN  = 32;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic ex_valid, ex_br_en, fetch_ready, imem_rsp_valid;
    logic [XLEN-1:0] ex_target;

    logic a_rv, a_fi, a_fd, a_st, a_sq, a_tr;
    logic [XLEN-1:0] a_pc, a_ta;
    logic [CNT_W-1:0] a_cnt;
    logic b_rv, b_fi, b_fd, b_st, b_sq, b_tr;
    logic [XLEN-1:0] b_pc, b_ta;
    logic [CNT_W-1:0] b_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.XLEN(XLEN), .INFLIGHT(2), .CNT_W(CNT_W)) dut_a (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_br_en(ex_br_en),
        .ex_target(ex_target), .fetch_ready(fetch_ready), .imem_rsp_valid(imem_rsp_valid),
        .redirect_valid(a_rv), .redirect_pc(a_pc), .flush_ifid(a_fi), .flush_idex(a_fd),
        .stall_ex(a_st), .squash_rsp(a_sq), .misalign_trap(a_tr), .trap_addr(a_ta),
        .taken_count(a_cnt)
    );

    branch_redirect_ctrl #(.XLEN(XLEN), .INFLIGHT(0), .CNT_W(CNT_W)) dut_b (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_br_en(ex_br_en),
        .ex_target(ex_target), .fetch_ready(fetch_ready), .imem_rsp_valid(imem_rsp_valid),
        .redirect_valid(b_rv), .redirect_pc(b_pc), .flush_ifid(b_fi), .flush_idex(b_fd),
        .stall_ex(b_st), .squash_rsp(b_sq), .misalign_trap(b_tr), .trap_addr(b_ta),
        .taken_count(b_cnt)
    );

    // Reference model: a pending redirect flag plus a count of responses left to drop.
    typedef struct {
        bit          redir;
        int          sq_left;
        logic [31:0] pc;
        bit          trap;
        logic [31:0] taddr;
        logic [31:0] cnt;
    } model_t;

    model_t m[2];
    int     infl[2] = '{2, 0};

    function automatic model_t model_reset();
        model_t z;
        z.redir = 0; z.sq_left = 0; z.pc = 0; z.trap = 0; z.taddr = 0; z.cnt = 0;
        return z;
    endfunction

    function automatic model_t mstep(model_t s, int inflight, logic v, logic br,
                                     logic [31:0] tgt, logic fr, logic im);
        model_t n = s;
        n.trap = 0;
        if (!s.redir && s.sq_left == 0) begin
            if (v && br) begin
                if (tgt % 4 != 0) begin
                    n.trap  = 1;
                    n.taddr = tgt;
                end else begin
                    n.redir = 1;
                    n.pc    = tgt;
                end
            end
        end else if (s.redir) begin
            if (fr) begin
                n.cnt     = s.cnt + 1;
                n.redir   = 0;
                n.sq_left = inflight;
            end
        end else if (im) begin
            n.sq_left = s.sq_left - 1;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_dut(input string d, input model_t e,
                           input logic rv, input logic fi, input logic fd, input logic st,
                           input logic sq, input logic tr, input logic [31:0] pc,
                           input logic [31:0] ta, input logic [31:0] cnt);
        bit busy = e.redir || (e.sq_left > 0);
        chk({d, " redirect_valid"}, {31'b0, rv}, {31'b0, e.redir});
        chk({d, " redirect_pc"},    pc,          e.pc);
        chk({d, " flush_ifid"},     {31'b0, fi}, {31'b0, busy});
        chk({d, " flush_idex"},     {31'b0, fd}, {31'b0, e.redir});
        chk({d, " stall_ex"},       {31'b0, st}, {31'b0, busy});
        chk({d, " squash_rsp"},     {31'b0, sq}, {31'b0, (e.sq_left > 0) && imem_rsp_valid});
        chk({d, " misalign_trap"},  {31'b0, tr}, {31'b0, e.trap});
        chk({d, " trap_addr"},      ta,          e.taddr);
        chk({d, " taken_count"},    cnt,         e.cnt);
    endtask

    task automatic check_all();
        chk_dut("A", m[0], a_rv, a_fi, a_fd, a_st, a_sq, a_tr, a_pc, a_ta, a_cnt);
        chk_dut("B", m[1], b_rv, b_fi, b_fd, b_st, b_sq, b_tr, b_pc, b_ta, b_cnt);
    endtask

    // One clock: drive inputs after the falling edge, check, then advance the model.
    task automatic cyc(input logic v, input logic br, input logic [31:0] tgt,
                       input logic fr, input logic im);
        @(negedge clk);
        ex_valid = v; ex_br_en = br; ex_target = tgt; fetch_ready = fr; imem_rsp_valid = im;
        #1;
        check_all();
        @(posedge clk);
        for (int d = 0; d < 2; d++) m[d] = mstep(m[d], infl[d], v, br, tgt, fr, im);
    endtask

    initial begin
        logic [31:0] rt;
        rst_n = 1'b0;
        ex_valid = 0; ex_br_en = 0; ex_target = 0; fetch_ready = 0; imem_rsp_valid = 0;
        m[0] = model_reset();
        m[1] = model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Aligned taken branch, accepted immediately, two wrong-path responses.
        cyc(1, 1, 32'h100, 0, 0);
        cyc(0, 0, 32'h0,   1, 0);
        cyc(0, 0, 32'h0,   0, 1);
        cyc(0, 0, 32'h0,   0, 1);
        cyc(0, 0, 32'h0,   0, 0);
        chk("A count after first redirect", a_cnt, 32'd1);
        chk("B count after first redirect", b_cnt, 32'd1);

        // Fetch stalls for 5 cycles while new branches to 0x200 are offered.
        cyc(1, 1, 32'h100, 0, 0);
        cyc(1, 1, 32'h200, 0, 0);
        cyc(0, 0, 32'h0,   0, 1);
        cyc(1, 1, 32'h200, 0, 0);
        cyc(0, 0, 32'h0,   0, 0);
        cyc(1, 1, 32'h200, 0, 1);
        cyc(0, 1, 32'h200, 1, 0);
        cyc(1, 1, 32'h200, 1, 0);
        cyc(0, 0, 32'h0,   0, 1);
        cyc(1, 1, 32'h200, 0, 0);
        cyc(0, 0, 32'h0,   0, 1);
        cyc(0, 0, 32'h0,   0, 0);
        chk("A pc after ignored branches", a_pc, 32'h100);
        chk("A count after stalled redirect", a_cnt, 32'd2);

        // Misaligned target, then an immediate new trigger on the trap cycle.
        cyc(1, 1, 32'h102, 1, 0);
        cyc(1, 1, 32'h301, 0, 0);
        cyc(0, 0, 32'h0,   0, 0);
        chk("A trap_addr after traps", a_ta, 32'h301);

        // Asynchronous reset while a redirect is pending.
        cyc(1, 1, 32'h100, 0, 0);
        cyc(0, 0, 32'h0,   0, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        m[0] = model_reset();
        m[1] = model_reset();
        check_all();
        chk("A count right after reset", a_cnt, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 0, 32'h0, 1, 1);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            rt = $urandom_range(0, 32'hFFFF) & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) rt[1:0] = 2'($urandom_range(1, 3));
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < 40), rt,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        #1;
        check_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
